// File: rtl/env_player_pkg.sv
// Shared defaults and state type for the per-channel pulse path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Used by env_player, its interface and sub-modules, and by the command
// register and DDS blocks that sit on either side of it.
package env_player_pkg;

  localparam int DEF_PHASE_WIDTH     = 14;
  localparam int DEF_FREQ_WIDTH      = 24;
  localparam int DEF_ENV_ADDR_WIDTH  = 12;
  localparam int DEF_ENV_LEN_WIDTH   = 12;
  localparam int DEF_SAMPLE_WIDTH    = 16;
  localparam int DEF_SAMPLES_PER_CLK = 4;
  localparam int DEF_MEM_LATENCY     = 2;

  // Player state: IDLE waits for a strobe, PLAY issues one read per clk.
  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/env_player_if.sv
// Bundle of command, envelope-memory read and sample-stream signals.
// Latency: none (wires only).
// Backpressure: none; the stream side has no ready, every word is taken.
//
// master : the envelope player (drives reads and the sample stream)
// slave  : the surroundings (command register, memory, DDS stage)
interface env_player_if
  import env_player_pkg::*;
#(
  parameter int PHASE_WIDTH     = DEF_PHASE_WIDTH,
  parameter int FREQ_WIDTH      = DEF_FREQ_WIDTH,
  parameter int ENV_ADDR_WIDTH  = DEF_ENV_ADDR_WIDTH,
  parameter int ENV_LEN_WIDTH   = DEF_ENV_LEN_WIDTH,
  parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int SAMPLES_PER_CLK = DEF_SAMPLES_PER_CLK
);

  // command side
  logic                                  cstrobe_in;
  logic [ENV_ADDR_WIDTH-1:0]             env_start;
  logic [ENV_LEN_WIDTH-1:0]              env_len;
  logic [PHASE_WIDTH-1:0]                phase_in;
  logic [FREQ_WIDTH-1:0]                 freq_in;
  // envelope memory read port
  logic                                  mem_ren;
  logic [ENV_ADDR_WIDTH-1:0]             mem_addr;
  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] mem_rdata;
  // sample stream to the DDS/multiplier stage
  logic                                  env_valid;
  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] env_data;
  logic                                  env_last;
  logic [PHASE_WIDTH-1:0]                phase_out;
  logic [FREQ_WIDTH-1:0]                 freq_out;
  logic                                  busy;

  modport master (
    input  cstrobe_in, env_start, env_len, phase_in, freq_in, mem_rdata,
    output mem_ren, mem_addr, env_valid, env_data, env_last,
           phase_out, freq_out, busy
  );

  modport slave (
    output cstrobe_in, env_start, env_len, phase_in, freq_in, mem_rdata,
    input  mem_ren, mem_addr, env_valid, env_data, env_last,
           phase_out, freq_out, busy
  );

endinterface

// File: rtl/env_player_tag_delay.sv
// Fixed-depth shift register that carries per-read tags alongside memory latency.
// Latency: DEPTH clk from i_d to o_q.
// Backpressure: none; shifts every clk.
//
// Ports: i_clk, i_rst_n (async active-low clear), i_d (tag in), o_q (tag out).
module env_player_tag_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/env_player.sv
// Plays one pulse envelope per command strobe: sequential memory reads, samples streamed out with phase/freq.
// Latency: strobe to first env_valid is MEM_LATENCY+2 clk; one word per clk thereafter.
// Backpressure: none; downstream must accept a word on every env_valid.
//
// Ports: clk, reset_n (async active-low), bus (env_player_if.master):
//   command  cstrobe_in/env_start/env_len/phase_in/freq_in
//   memory   mem_ren/mem_addr out, mem_rdata in (valid MEM_LATENCY clk after mem_ren)
//   stream   env_valid/env_data/env_last/phase_out/freq_out, busy while reads issue
module env_player
  import env_player_pkg::*;
#(
  parameter int PHASE_WIDTH     = DEF_PHASE_WIDTH,
  parameter int FREQ_WIDTH      = DEF_FREQ_WIDTH,
  parameter int ENV_ADDR_WIDTH  = DEF_ENV_ADDR_WIDTH,
  parameter int ENV_LEN_WIDTH   = DEF_ENV_LEN_WIDTH,
  parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int SAMPLES_PER_CLK = DEF_SAMPLES_PER_CLK,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input logic          clk,
  input logic          reset_n,
  env_player_if.master bus
);

  localparam int WORD_WIDTH = SAMPLES_PER_CLK * SAMPLE_WIDTH;
  localparam int TAG_WIDTH  = 2 + PHASE_WIDTH + FREQ_WIDTH;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [ENV_ADDR_WIDTH-1:0] r_addr;
  logic [ENV_LEN_WIDTH-1:0]  r_cnt;     // reads left including the current one
  logic [PHASE_WIDTH-1:0]    r_phase;
  logic [FREQ_WIDTH-1:0]     r_freq;

  logic w_start;   // strobe that (re)starts a pulse
  logic w_kill;    // zero-length strobe: abort whatever is playing
  logic w_mem_ren;
  logic [ENV_ADDR_WIDTH-1:0] w_mem_addr;
  logic w_tag_last;

  logic [TAG_WIDTH-1:0]   w_dly_tag;
  logic                   w_dly_valid;
  logic                   w_dly_last;
  logic [PHASE_WIDTH-1:0] w_dly_phase;
  logic [FREQ_WIDTH-1:0]  w_dly_freq;

  logic                   r_env_valid;
  logic [WORD_WIDTH-1:0]  r_env_data;
  logic                   r_env_last;
  logic [PHASE_WIDTH-1:0] r_phase_out;
  logic [FREQ_WIDTH-1:0]  r_freq_out;

  assign w_start = bus.cstrobe_in && (bus.env_len != '0);
  assign w_kill  = bus.cstrobe_in && (bus.env_len == '0);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state: a strobe wins over everything, so a strobe in the final
  // read cycle chains straight into the next pulse with no bubble
  always_comb begin
    w_state_nxt = r_state;
    if (w_start)                                         w_state_nxt = PLAY;
    else if (w_kill)                                     w_state_nxt = IDLE;
    else if (r_state == PLAY && r_cnt == ENV_LEN_WIDTH'(1)) w_state_nxt = IDLE;
  end

  // outputs of the read-issue FSM
  always_comb begin
    w_mem_ren  = 1'b0;
    w_mem_addr = '0;
    w_tag_last = 1'b0;
    if (r_state == PLAY) begin
      w_mem_ren  = 1'b1;
      w_mem_addr = r_addr;
      w_tag_last = (r_cnt == ENV_LEN_WIDTH'(1));
    end
  end

  // per-pulse parameters and read pointer; address wraps by truncation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_freq  <= '0;
    end else if (w_start) begin
      r_addr  <= bus.env_start;
      r_cnt   <= bus.env_len;
      r_phase <= bus.phase_in;
      r_freq  <= bus.freq_in;
    end else if (r_state == PLAY) begin
      r_addr  <= r_addr + ENV_ADDR_WIDTH'(1);
      r_cnt   <= r_cnt - ENV_LEN_WIDTH'(1);
    end
  end

  // Tags ride alongside the read so words already in flight at a pre-empt
  // keep the old phase/freq; an aborted pulse never launched a last tag.
  env_player_tag_delay #(
    .DEPTH (MEM_LATENCY),
    .WIDTH (TAG_WIDTH)
  ) u_tag_delay (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     ({w_mem_ren, w_tag_last, r_phase, r_freq}),
    .o_q     (w_dly_tag)
  );

  assign {w_dly_valid, w_dly_last, w_dly_phase, w_dly_freq} = w_dly_tag;

  // output stage: data zeroed between words, phase/freq held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_env_valid <= 1'b0;
      r_env_data  <= '0;
      r_env_last  <= 1'b0;
      r_phase_out <= '0;
      r_freq_out  <= '0;
    end else begin
      r_env_valid <= w_dly_valid;
      r_env_last  <= w_dly_valid & w_dly_last;
      r_env_data  <= w_dly_valid ? bus.mem_rdata : '0;
      if (w_dly_valid) begin
        r_phase_out <= w_dly_phase;
        r_freq_out  <= w_dly_freq;
      end
    end
  end

  assign bus.mem_ren   = w_mem_ren;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.busy      = w_mem_ren;
  assign bus.env_valid = r_env_valid;
  assign bus.env_data  = r_env_data;
  assign bus.env_last  = r_env_last;
  assign bus.phase_out = r_phase_out;
  assign bus.freq_out  = r_freq_out;

endmodule
